// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : regfile_scoreboard
// Brief    : Hazard scoreboard for the 32x32 MIPS32 register file. Tracks
//            registers with an in-flight write, gates issue on RAW/WAW
//            hazards, clears pending state on writeback commit.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                issue_valid,
    input  logic [ADDR_W-1:0]   issue_rs,
    input  logic                issue_rs_used,
    input  logic [ADDR_W-1:0]   issue_rt,
    input  logic                issue_rt_used,
    input  logic [ADDR_W-1:0]   issue_rd,
    input  logic                issue_we,
    output logic                issue_ready,
    input  logic                wb_valid,
    input  logic [ADDR_W-1:0]   wb_dest,
    input  logic                flush,
    output logic [NUM_REGS-1:0] pending_mask,
    output logic                busy,
    output logic [CNT_W-1:0]    stall_count,
    output logic                wb_err
);

    localparam logic [CNT_W-1:0]  c_cnt_max = {CNT_W{1'b1}};
    localparam logic [ADDR_W-1:0] c_zero_reg = '0;

    logic [NUM_REGS-1:0] r_pending;
    logic [NUM_REGS-1:0] w_pending_nxt;
    logic [CNT_W-1:0]    r_stall_count;
    logic                r_wb_err;

    logic w_rs_hit;
    logic w_rt_hit;
    logic w_rd_hit;
    logic w_fire;
    logic w_wb_live;
    logic w_wb_bad;

    // Hazard detection looks only at registered pending bits, so a writeback
    // in the same cycle never unblocks a reader (no bypass).
    assign w_rs_hit    = issue_rs_used && (issue_rs != c_zero_reg) && r_pending[issue_rs];
    assign w_rt_hit    = issue_rt_used && (issue_rt != c_zero_reg) && r_pending[issue_rt];
    assign w_rd_hit    = issue_we      && (issue_rd != c_zero_reg) && r_pending[issue_rd];
    assign issue_ready = !(w_rs_hit || w_rt_hit || w_rd_hit);
    assign w_fire      = issue_valid && issue_ready;

    assign w_wb_live   = wb_valid && (wb_dest != c_zero_reg);
    // A stray writeback during a flush is expected debris, not an error.
    assign w_wb_bad    = w_wb_live && !r_pending[wb_dest] && !flush;

    // Next pending state: clear on writeback, then set on issue (set wins),
    // bit 0 forced low, flush overrides everything.
    always_comb begin
        w_pending_nxt = r_pending;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (w_wb_live && (wb_dest == ADDR_W'(i))) begin
                w_pending_nxt[i] = 1'b0;
            end
            if (w_fire && issue_we && (issue_rd == ADDR_W'(i))) begin
                w_pending_nxt[i] = 1'b1;
            end
        end
        w_pending_nxt[0] = 1'b0;
        if (flush) begin
            w_pending_nxt = '0;
        end
    end

    // Pending-bit register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_nxt;
        end
    end

    // Saturating count of cycles where decode presented an instruction but it stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_count <= '0;
        end else if (issue_valid && !issue_ready && (r_stall_count != c_cnt_max)) begin
            r_stall_count <= r_stall_count + CNT_W'(1);
        end
    end

    // Sticky flag for a writeback to a register that had no in-flight write.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wb_err <= 1'b0;
        end else if (w_wb_bad) begin
            r_wb_err <= 1'b1;
        end
    end

    assign pending_mask = r_pending;
    assign busy         = |r_pending;
    assign stall_count  = r_stall_count;
    assign wb_err       = r_wb_err;

endmodule
`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_scoreboard
// Brief    : Directed self-checking bench for regfile_scoreboard. Expected
//            values are queued as stimulus is driven and popped at checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_scoreboard;

    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int CNT_W    = 16;

    logic                clk;
    logic                reset;
    logic                issue_valid;
    logic [ADDR_W-1:0]   issue_rs;
    logic                issue_rs_used;
    logic [ADDR_W-1:0]   issue_rt;
    logic                issue_rt_used;
    logic [ADDR_W-1:0]   issue_rd;
    logic                issue_we;
    logic                issue_ready;
    logic                wb_valid;
    logic [ADDR_W-1:0]   wb_dest;
    logic                flush;
    logic [NUM_REGS-1:0] pending_mask;
    logic                busy;
    logic [CNT_W-1:0]    stall_count;
    logic                wb_err;

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .CNT_W    (CNT_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .issue_valid   (issue_valid),
        .issue_rs      (issue_rs),
        .issue_rs_used (issue_rs_used),
        .issue_rt      (issue_rt),
        .issue_rt_used (issue_rt_used),
        .issue_rd      (issue_rd),
        .issue_we      (issue_we),
        .issue_ready   (issue_ready),
        .wb_valid      (wb_valid),
        .wb_dest       (wb_dest),
        .flush         (flush),
        .pending_mask  (pending_mask),
        .busy          (busy),
        .stall_count   (stall_count),
        .wb_err        (wb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   exp_stall = 0;

    task automatic expect_val(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic check_pop(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty observed=%0h expected=<none>", obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    // Advance one clock and settle 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        issue_valid   = 1'b0;
        issue_rs      = '0;
        issue_rs_used = 1'b0;
        issue_rt      = '0;
        issue_rt_used = 1'b0;
        issue_rd      = '0;
        issue_we      = 1'b0;
        wb_valid      = 1'b0;
        wb_dest       = '0;
        flush         = 1'b0;
    endtask

    task automatic issue_write(input logic [ADDR_W-1:0] rd);
        idle_inputs();
        issue_valid = 1'b1;
        issue_rd    = rd;
        issue_we    = 1'b1;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;

        // Reset state.
        expect_val("rst_mask", 32'h0);
        expect_val("rst_busy", 32'h0);
        expect_val("rst_stall", 32'h0);
        expect_val("rst_wberr", 32'h0);
        expect_val("rst_ready", 32'h1);
        check_pop(pending_mask);
        check_pop({31'b0, busy});
        check_pop({16'b0, stall_count});
        check_pop({31'b0, wb_err});
        check_pop({31'b0, issue_ready});

        // Issue a write to r5.
        issue_write(5'd5);
        expect_val("issue_r5_ready", 32'h1);
        check_pop({31'b0, issue_ready});
        step();
        idle_inputs();
        expect_val("r5_mask", 32'h0000_0020);
        expect_val("r5_busy", 32'h1);
        check_pop(pending_mask);
        check_pop({31'b0, busy});

        // RAW on rs=5 stalls; count climbs one per cycle.
        issue_valid = 1'b1; issue_rs = 5'd5; issue_rs_used = 1'b1;
        expect_val("raw_ready", 32'h0);
        check_pop({31'b0, issue_ready});
        step(); exp_stall++;
        expect_val("raw_stall1", 32'(exp_stall));
        check_pop({16'b0, stall_count});
        step(); exp_stall++;
        expect_val("raw_stall2", 32'(exp_stall));
        check_pop({16'b0, stall_count});

        // Writeback of r5 in cycle N does not unblock the reader in N.
        wb_valid = 1'b1; wb_dest = 5'd5;
        expect_val("nobypass_ready_N", 32'h0);
        check_pop({31'b0, issue_ready});
        step(); exp_stall++;
        wb_valid = 1'b0; wb_dest = '0;
        expect_val("bypass_ready_N1", 32'h1);
        expect_val("wb_mask", 32'h0);
        expect_val("wb_stall3", 32'(exp_stall));
        expect_val("wb_err_clean", 32'h0);
        check_pop({31'b0, issue_ready});
        check_pop(pending_mask);
        check_pop({16'b0, stall_count});
        check_pop({31'b0, wb_err});
        step();
        idle_inputs();

        // Register 0 never hazards and is never tracked.
        issue_write(5'd0);
        issue_rs_used = 1'b1; issue_rt_used = 1'b1;
        wb_valid = 1'b1; wb_dest = 5'd0;
        step();
        expect_val("r0_ready", 32'h1);
        check_pop({31'b0, issue_ready});
        step();
        idle_inputs();
        expect_val("r0_mask", 32'h0);
        expect_val("r0_wberr", 32'h0);
        check_pop(pending_mask);
        check_pop({31'b0, wb_err});

        // Pend r3, r4, r31, then flush alongside an issue of r8 and a stray writeback.
        issue_write(5'd3);  step();
        issue_write(5'd4);  step();
        issue_write(5'd31); step();
        idle_inputs();
        expect_val("pre_flush_mask", 32'h8000_0018);
        check_pop(pending_mask);
        issue_write(5'd8);
        flush = 1'b1; wb_valid = 1'b1; wb_dest = 5'd9;
        step();
        idle_inputs();
        expect_val("flush_mask", 32'h0);
        expect_val("flush_busy", 32'h0);
        expect_val("flush_wberr", 32'h0);
        expect_val("flush_stall", 32'(exp_stall));
        check_pop(pending_mask);
        check_pop({31'b0, busy});
        check_pop({31'b0, wb_err});
        check_pop({16'b0, stall_count});

        // WAW on r7 stalls; same-cycle writeback to non-pending r9 raises wb_err.
        issue_write(5'd7); step();
        issue_write(5'd7);
        wb_valid = 1'b1; wb_dest = 5'd9;
        expect_val("waw_ready", 32'h0);
        check_pop({31'b0, issue_ready});
        step(); exp_stall++;
        idle_inputs();
        expect_val("waw_wberr", 32'h1);
        expect_val("waw_mask", 32'h0000_0080);
        expect_val("waw_stall", 32'(exp_stall));
        check_pop({31'b0, wb_err});
        check_pop(pending_mask);
        check_pop({16'b0, stall_count});
        step(); step();
        expect_val("wberr_sticky", 32'h1);
        check_pop({31'b0, wb_err});

        // Same-cycle clear and set of r7: set wins.
        wb_valid = 1'b1; wb_dest = 5'd7;
        step();
        idle_inputs();
        issue_write(5'd7);
        wb_valid = 1'b1; wb_dest = 5'd7;
        step();
        idle_inputs();
        expect_val("setwins_mask", 32'h0000_0080);
        check_pop(pending_mask);

        // Long RAW stall on r7 saturates the counter.
        issue_valid = 1'b1; issue_rs = 5'd7; issue_rs_used = 1'b1;
        for (int i = 0; i < 70000; i++) begin
            step();
        end
        expect_val("sat_stall", 32'h0000_FFFF);
        check_pop({16'b0, stall_count});
        step();
        expect_val("sat_nowrap", 32'h0000_FFFF);
        check_pop({16'b0, stall_count});

        // Reset mid-stall clears everything.
        reset = 1'b1;
        step();
        reset = 1'b0;
        expect_val("midrst_mask", 32'h0);
        expect_val("midrst_stall", 32'h0);
        expect_val("midrst_wberr", 32'h0);
        expect_val("midrst_ready", 32'h1);
        check_pop(pending_mask);
        check_pop({16'b0, stall_count});
        check_pop({31'b0, wb_err});
        check_pop({31'b0, issue_ready});
        idle_inputs();
        step();

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
